// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state/grant types and counter width for the data-memory arbiter
package dmem_arb_pkg;
   typedef enum logic {ARB_IDLE, ARB_CPU_RD_PEND} arb_state_e;
   typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_HOST} arb_gnt_e;
   localparam int WAIT_W = 4;
endpackage

// File: rtl/dmem_arb_age_cnt.sv
// dmem_arb_age_cnt: saturating count of consecutive cycles the host has lost arbitration
module dmem_arb_age_cnt import dmem_arb_pkg::*; #(
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inc,
   input  logic              clr,
   output logic [WAIT_W-1:0] cnt,
   output logic              sat
);
   assign sat = cnt == WAIT_W'(MAX_WAIT);
   // count host losses, holding at MAX_WAIT until the host is served or withdraws
   always_ff @(posedge clk)
      if (!reset || clr) cnt <= '0;
      else if (inc && !sat) cnt <= cnt + 1'b1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core/host arbiter for a synchronous single-port data RAM (optional perf counters: DMEM_ARB_PERF_CNT_EN)
module dmem_arbiter import dmem_arb_pkg::*; #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ready,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_CNT_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_host_cnt
`endif
);
   arb_state_e        state, state_nxt;
   arb_gnt_e          gnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              wait_sat, rd_host_q;

   dmem_arb_age_cnt #(.MAX_WAIT(MAX_WAIT)) u_age (
      .clk   (clk),
      .reset (reset),
      .inc   (host_req && !host_ready),
      .clr   (!host_req || host_ready),
      .cnt   (wait_cnt),
      .sat   (wait_sat)
   );

   // grant selection, next state and RAM/handshake drive; a pending core load blocks core re-issue
   always_comb begin
      gnt = !reset ? GNT_NONE :
            state == ARB_CPU_RD_PEND ? (host_req ? GNT_HOST : GNT_NONE) :
            host_req && (!cpu_req || wait_sat) ? GNT_HOST :
            cpu_req ? GNT_CPU : GNT_NONE;
      state_nxt = gnt == GNT_CPU && !cpu_we ? ARB_CPU_RD_PEND : ARB_IDLE;
      host_ready = gnt == GNT_HOST;
      cpu_stall = reset && state == ARB_IDLE && cpu_req && !(gnt == GNT_CPU && cpu_we);
      mem_en = gnt != GNT_NONE;
      mem_we = host_ready ? host_we : gnt == GNT_CPU && cpu_we;
      mem_addr = host_ready ? host_addr : cpu_addr;
      mem_wdata = host_ready ? host_wdata : cpu_wdata;
   end

   // state register and flag marking that the data arriving next cycle belongs to the host
   always_ff @(posedge clk)
      if (!reset) begin
         state <= ARB_IDLE;
         rd_host_q <= 1'b0;
      end else begin
         state <= state_nxt;
         rd_host_q <= host_ready && !host_we;
      end

   assign host_rvalid = rd_host_q && reset;
   assign host_rdata = mem_rdata;
   assign cpu_rdata = mem_rdata;

`ifdef DMEM_ARB_PERF_CNT_EN
   // free-running event counters for core stall cycles and host grants
   always_ff @(posedge clk)
      if (!reset) begin
         perf_stall_cnt <= '0;
         perf_host_cnt <= '0;
      end else begin
         perf_stall_cnt <= perf_stall_cnt + 32'(cpu_stall);
         perf_host_cnt <= perf_host_cnt + 32'(host_ready);
      end
`endif
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares one synchronous single-port data RAM between the Tessia core's data port and a host agent (program/data loader or debug master). The core has priority. A starvation counter guarantees the host a slot. The arbiter generates the core stall that a synchronous-read RAM requires. It sits between the core's MemWrite/ALUResult/WriteData/ReadData pins and the RAM.

Parameters:
ADDR_W, 32, address width of both requesters and the RAM
DATA_W, 32, data width
MAX_WAIT, 4, consecutive cycles the host may lose arbitration before it is forced a grant (range 1..15)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
cpu_req  in  1  core requests a data access this cycle (load or store)
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_W  core byte address
cpu_wdata  in  DATA_W  core store data
cpu_rdata  out  DATA_W  load data to core
cpu_stall  out  1  freezes core PC and register write this cycle
host_req  in  1  host valid; held with fields stable until accepted
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_ready  out  1  host request accepted this cycle
host_rvalid  out  1  one-cycle pulse, host_rdata valid
host_rdata  out  DATA_W  host read data
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read issue

Behaviour:
- RAM: one access per cycle; read data appears the cycle after issue.
- FSM states:
  - IDLE: CPU_RD_PEND = 0.
  - CPU_RD_PEND: core load issued last cycle; data is arriving now.
- Grant, combinational, in IDLE:
  - Core only: core wins.
  - Host only: host wins.
  - Both: core wins unless wait_cnt == MAX_WAIT, in which case host wins.
- Grant in CPU_RD_PEND:
  - The core's still-asserted cpu_req is the same load and is never re-issued.
  - Only the host may be granted.
- Core store granted: mem_we = 1, cpu_stall = 0, completes in 1 cycle.
- Core load granted:
  - Issue cycle: cpu_stall = 1; next state is CPU_RD_PEND.
  - CPU_RD_PEND cycle: cpu_rdata = mem_rdata, cpu_stall = 0; return to IDLE. Load latency is 2 cycles.
- Core request losing to the host: cpu_stall = 1 and the request retries next cycle.
- Host handshake: transfer occurs when host_req && host_ready. On a read, host_rvalid = 1 exactly one cycle later with host_rdata = mem_rdata.
- Pipelining: a host read issued in CPU_RD_PEND overlaps with the core's data return. Both complete correctly.
- wait_cnt:
  - Increments when host_req && !host_ready.
  - Saturates at MAX_WAIT.
  - Clears to 0 on host grant or when host_req = 0.
- No request pending: mem_en = 0 and mem_we = 0.
- Reset (reset == 0 at clk edge):
  - State returns to IDLE; wait_cnt, host_rvalid and the registered read-owner flag clear to 0.
  - Combinational outputs are forced to 0 while reset is low: cpu_stall, host_ready, mem_en, mem_we.
  - An in-flight read is dropped: no host_rvalid pulse and no core data return after reset.
- cpu_rdata and host_rdata are don't-care except in their valid cycles. The bench checks them only then.

Optional Feature:
- Macro: DMEM_ARB_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_stall_cnt [31:0] and perf_host_cnt [31:0].
  - perf_stall_cnt counts cycles with cpu_stall = 1; perf_host_cnt counts host grants.
  - Both wrap at 2^32 and clear on reset.
- When undefined: the ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package dmem_arb_pkg:
  - State enum {ARB_IDLE, ARB_CPU_RD_PEND}.
  - Grant enum {GNT_NONE, GNT_CPU, GNT_HOST}.
  - Localparam WAIT_W = 4.
- One sub-module, dmem_arb_age_cnt: saturating host wait counter with inc/clr/sat outputs, parameterised by MAX_WAIT.

Test Plan:
- Core store alone, addr 0x10, wdata 0xDEADBEEF → mem_we = 1 that cycle, cpu_stall = 0. A later host read of 0x10 gives host_rvalid with 0xDEADBEEF one cycle after host_ready.
- Core load alone, addr 0x10 → cpu_stall = 1 in cycle N. cpu_rdata = 0xDEADBEEF with cpu_stall = 0 in N+1. mem_en is high only in N for the core.
- Core stores every cycle while host holds a read of 0x20, MAX_WAIT = 4 → host_ready is 0 for 4 cycles and 1 on the 5th. cpu_stall = 1 in that cycle only.
- Core load and host read together in IDLE → core issues in N. Host is granted in N+1, overlapping the core data return. host_rvalid arrives in N+2 with correct data.
- reset driven low in the cycle after a host read is accepted → host_rvalid never pulses. After release all outputs are 0 and wait_cnt = 0.
- With DMEM_ARB_PERF_CNT_EN: 3 core loads and 2 host grants → perf_stall_cnt = 3, perf_host_cnt = 2.
